bitstream_decoder: RTL and testbench
====================================

# bitstream_decoder

Converts a unipolar stochastic bitstream back to a binary value by counting ones over a fixed window. It sits at the output end of the bitstream network, for example after the sigmoid or exponential stages. It returns results to the binary domain, where a register interface or testbench can read them. A start/valid/ready handshake frames each measurement, and an optional warm-up period discards samples while upstream pipelines settle.

## Interface
Parameters:
- WIDTH, 8: width of the result `y`.
- LENGTH, 256: number of samples accumulated per measurement. Must be ≥ 1.
- WARMUP, 0: number of samples discarded before accumulation begins. May be 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  1  stochastic bitstream input; sampled on every rising edge while in WARM or ACCUM.
- start  input  1  requests a measurement; honoured only in IDLE, or in DONE on the handshake edge.
- ready  input  1  consumer accepts the result.
- busy  output  1  high in WARM and ACCUM.
- valid  output  1  high in DONE; result available.
- y  output  WIDTH  count of ones in the window, saturated to 2^WIDTH−1.
- sat  output  1  high when the raw count exceeded 2^WIDTH−1; valid only while `valid`=1.

## Operation
- States:
  - IDLE: start=1 → WARM if WARMUP>0, otherwise ACCUM; start=0 → stay.
  - WARM: sample counter cnt increments each edge. After WARMUP samples, go to ACCUM with cnt=0. Samples of x are discarded.
  - ACCUM: each edge, ones += x and cnt++. After LENGTH samples, go to DONE.
  - DONE: register y and sat. valid=1.
    - ready=1 and start=1 → WARM or ACCUM (back-to-back measurement).
    - ready=1 and start=0 → IDLE.
    - ready=0 → hold.
- Counter widths:
  - ones is $clog2(LENGTH+1) bits, so LENGTH consecutive ones never wrap.
  - cnt is wide enough for max(LENGTH, WARMUP).
- Result:
  - y = (ones > 2^WIDTH−1) ? 2^WIDTH−1 : ones[WIDTH-1:0].
  - sat = (ones > 2^WIDTH−1).
  - Defaults give ones in 0..256; all-ones input yields y=255, sat=1.
- ones and cnt are cleared on every entry to WARM or ACCUM. No accumulation leaks between measurements.
- y and sat hold their last values outside DONE. Consumers use them only while valid=1.
- start outside IDLE and DONE is ignored. There is no abort input; rst is the only way to cancel a measurement.
- x is treated as synchronous to clk; no synchroniser is included.

## Timing
- Reset values (asynchronous, immediate on rst rising, including mid-measurement):
  - state=IDLE, busy=0, valid=0, y=0, sat=0, ones=0, cnt=0.
  - First possible start is the first edge after rst falls.
- Latency, where E0 is the edge that samples start=1:
  - busy rises after E0.
  - x is sampled on edges E1..E(WARMUP+LENGTH).
  - Only edges E(WARMUP+1)..E(WARMUP+LENGTH) count.
  - valid rises after edge E(WARMUP+LENGTH), and busy falls on the same edge.
- Handshake:
  - A transfer occurs on an edge with valid=1 and ready=1; valid falls after that edge.
  - With start=1 on the transfer edge, the next measurement's first sample is the following edge. Throughput is one result per WARMUP+LENGTH+1 cycles.
  - ready is ignored when valid=0.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset: assert rst mid-ACCUM at default parameters → busy=0, valid=0, y=0, sat=0 immediately. The next start yields a fresh count with no residue.
- Constant streams, defaults: x=0 for 256 samples → y=0, sat=0. x=1 → y=255, sat=1. valid rises exactly 256 edges after the start edge.
- Known density: LENGTH=256, x=1 on every 4th sample → y=64, sat=0. x from a 3/4-density LFSR comparator → y within ±16 of 192.
- Warm-up: WARMUP=5, LENGTH=16, x=1 for the first 5 samples then 0 → y=0. valid rises 21 edges after the start edge.
- Backpressure and back-to-back: hold ready=0 for 10 cycles in DONE → valid, y and sat stable. Then ready=1 with start=1 → valid falls and busy rises the same edge, and the next result is correct.
- Ignored start: pulse start during ACCUM → no restart, and the result equals the count of the original window only.

Source files
------------

// File: rtl/bitstream_decoder.sv
// -----------------------------------------------------------------------------
// bitstream_decoder
//
// Turns a unipolar stochastic bitstream back into a binary value by counting
// the ones seen over a fixed window of LENGTH samples. An optional warm-up
// period of WARMUP samples is discarded first so upstream pipelines can settle.
// Each measurement is framed by a start request and a valid/ready handoff of
// the result.
//
// Parameters
//   WIDTH  : width of the result y
//   LENGTH : samples accumulated per measurement (>= 1)
//   WARMUP : samples discarded before accumulation (>= 0)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   x     in   stochastic bitstream, sampled every edge in WARM/ACCUM
//   start in   measurement request (taken in IDLE, or in DONE on handshake)
//   ready in   consumer accepts the result
//   busy  out  measurement in progress (WARM or ACCUM)
//   valid out  result available (DONE)
//   y     out  count of ones, saturated to 2^WIDTH-1
//   sat   out  raw count exceeded 2^WIDTH-1 (meaningful while valid)
// -----------------------------------------------------------------------------
module bitstream_decoder #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 256,
   parameter int WARMUP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             start,
   input  logic             ready,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] y,
   output logic             sat
);

   localparam int CNT_MAX = (LENGTH > WARMUP) ? LENGTH : WARMUP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int OW      = $clog2(LENGTH + 1);

   // Terminal counts: the transition fires on the edge that takes the last sample.
   localparam logic [CW-1:0] LAST_ACC  = CW'(LENGTH - 1);
   localparam logic [CW-1:0] LAST_WARM = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);
   localparam logic [63:0]   Y_MAX     = (64'd1 << WIDTH) - 64'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WARM  = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Where a new measurement begins; fixed by the WARMUP parameter.
   localparam state_t FIRST_STATE = (WARMUP > 0) ? WARM : ACCUM;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [OW-1:0]    ones_reg, ones_next;
   logic [WIDTH-1:0] y_reg, y_next;
   logic             sat_reg, sat_next;
   logic             busy_reg, busy_next;
   logic             valid_reg, valid_next;

   // Running count including the sample on the current edge.
   logic [OW-1:0]    ones_sum;
   logic             over_max;

   assign ones_sum = ones_reg + OW'(x);
   assign over_max = (64'(ones_sum) > Y_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ones_reg  <= '0;
         y_reg     <= '0;
         sat_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ones_reg  <= ones_next;
         y_reg     <= y_next;
         sat_reg   <= sat_next;
         busy_reg  <= busy_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ones_next  = ones_reg;
      y_next     = y_reg;
      sat_next   = sat_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FIRST_STATE;
               cnt_next   = '0;
               ones_next  = '0;
            end
         end
         WARM: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_WARM) begin
               state_next = ACCUM;
               cnt_next   = '0;
               ones_next  = '0;
            end
         end
         ACCUM: begin
            cnt_next  = cnt_reg + 1'b1;
            ones_next = ones_sum;
            if (cnt_reg == LAST_ACC) begin
               // Capture the result from the count that includes this last sample.
               state_next = DONE;
               cnt_next   = '0;
               sat_next   = over_max;
               y_next     = over_max ? {WIDTH{1'b1}} : WIDTH'(ones_sum);
            end
         end
         DONE: begin
            if (ready) begin
               if (start) begin
                  state_next = FIRST_STATE;
                  cnt_next   = '0;
                  ones_next  = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Status flags are registered from the next state so outputs come
      // straight from flops.
      busy_next  = (state_next == WARM) || (state_next == ACCUM);
      valid_next = (state_next == DONE);
   end

   assign busy  = busy_reg;
   assign valid = valid_reg;
   assign y     = y_reg;
   assign sat   = sat_reg;

endmodule

// File: tb/tb_bitstream_decoder.sv
module tb_bitstream_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       x   = 1'b0;
   // default-parameter instance
   logic       start_d = 1'b0, ready_d = 1'b0;
   logic       busy_d, valid_d, sat_d;
   logic [7:0] y_d;
   // warm-up instance (WARMUP=5, LENGTH=16)
   logic       start_w = 1'b0, ready_w = 1'b0;
   logic       busy_w, valid_w, sat_w;
   logic [7:0] y_w;

   always #5 clk = ~clk;

   bitstream_decoder u_def (
      .clk(clk), .rst(rst), .x(x), .start(start_d), .ready(ready_d),
      .busy(busy_d), .valid(valid_d), .y(y_d), .sat(sat_d)
   );

   bitstream_decoder #(.WIDTH(8), .LENGTH(16), .WARMUP(5)) u_warm (
      .clk(clk), .rst(rst), .x(x), .start(start_w), .ready(ready_w),
      .busy(busy_w), .valid(valid_w), .y(y_w), .sat(sat_w)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit lfsr_bits [256];

   typedef struct {
      int kind;
      int exp_y;
      int tol;
      bit exp_sat;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int exp, input int tol);
      n_checks++;
      if (act < exp - tol || act > exp + tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   function automatic bit pat(input int kind, input int i);
      case (kind)
         0: return 1'b0;
         1: return 1'b1;
         2: return (i % 4) == 0;
         3: return (i % 3) == 0;
         4: return i < 255;
         5: return (i % 2) == 1;
         6: return (i < 256) ? lfsr_bits[i] : 1'b0;
         7: return i < 5;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit cur_busy(input int sel);
      return (sel != 0) ? busy_w : busy_d;
   endfunction
   function automatic bit cur_valid(input int sel);
      return (sel != 0) ? valid_w : valid_d;
   endfunction

   task automatic set_start(input int sel, input bit v);
      if (sel != 0) start_w = v; else start_d = v;
   endtask
   task automatic set_ready(input int sel, input bit v);
      if (sel != 0) ready_w = v; else ready_d = v;
   endtask

   // Called at the negedge right after the start edge E0. Drives samples and
   // counts edges until valid; pulse_at >= 0 raises start for one cycle mid-run.
   task automatic collect(input int sel, input int kind, input int total, input int pulse_at,
                          output int ry, output bit rsat, output int lat);
      int n;
      n = 0;
      set_start(sel, 1'b0);
      set_ready(sel, 1'b0);
      x = pat(kind, 0);
      while (!cur_valid(sel) && n < total + 50) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         x = (n < total) ? pat(kind, n) : 1'b0;
         set_start(sel, n == pulse_at);
      end
      set_start(sel, 1'b0);
      x = 1'b0;
      if (!cur_valid(sel)) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: valid not seen after %0d edges", n);
      end
      ry   = (sel != 0) ? int'(y_w) : int'(y_d);
      rsat = (sel != 0) ? sat_w : sat_d;
      lat  = n;
   endtask

   task automatic run_meas(input int sel, input int kind, input int total, input int pulse_at,
                           output int ry, output bit rsat, output int lat);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("busy_after_start", int'(cur_busy(sel)), 1);
      collect(sel, kind, total, pulse_at, ry, rsat, lat);
   endtask

   task automatic release_result(input int sel);
      set_ready(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_ready(sel, 1'b0);
      check("valid_after_xfer", int'(cur_valid(sel)), 0);
   endtask

   initial begin
      int  ry, lat;
      bit  rsat;
      bit  stable;
      logic [7:0] s;

      s = 8'h01;
      for (int i = 0; i < 256; i++) begin
         lfsr_bits[i] = (s < 8'd192);
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end

      vecs[0] = '{kind: 0, exp_y: 0,   tol: 0,  exp_sat: 1'b0};
      vecs[1] = '{kind: 1, exp_y: 255, tol: 0,  exp_sat: 1'b1};
      vecs[2] = '{kind: 2, exp_y: 64,  tol: 0,  exp_sat: 1'b0};
      vecs[3] = '{kind: 3, exp_y: 86,  tol: 0,  exp_sat: 1'b0};
      vecs[4] = '{kind: 4, exp_y: 255, tol: 0,  exp_sat: 1'b0};
      vecs[5] = '{kind: 5, exp_y: 128, tol: 0,  exp_sat: 1'b0};
      vecs[6] = '{kind: 6, exp_y: 192, tol: 16, exp_sat: 1'b0};

      // reset state
      #2;
      check("rst_busy",  int'(busy_d),  0);
      check("rst_valid", int'(valid_d), 0);
      check("rst_y",     int'(y_d),     0);
      check("rst_sat",   int'(sat_d),   0);
      @(negedge clk);
      rst = 1'b0;

      // table-driven constant and density streams, default parameters
      foreach (vecs[k]) begin
         run_meas(0, vecs[k].kind, 256, -1, ry, rsat, lat);
         $display("vec %0d kind %0d: y=%0d sat=%0d latency=%0d", k, vecs[k].kind, ry, rsat, lat);
         check_range("vec_y", ry, vecs[k].exp_y, vecs[k].tol);
         check("vec_sat", int'(rsat), int'(vecs[k].exp_sat));
         check("vec_latency", lat, 256);
         release_result(0);
      end

      // warm-up: ones only in the discarded samples
      run_meas(1, 7, 21, -1, ry, rsat, lat);
      $display("warm kind 7: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("warm_y", ry, 0);
      check("warm_sat", int'(rsat), 0);
      check("warm_latency", lat, 21);
      release_result(1);

      // warm-up: all ones, only the 16 counted samples contribute
      run_meas(1, 1, 21, -1, ry, rsat, lat);
      $display("warm kind 1: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("warm_all_y", ry, 16);
      check("warm_all_latency", lat, 21);
      release_result(1);

      // backpressure then back-to-back
      run_meas(0, 2, 256, -1, ry, rsat, lat);
      $display("bp first: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("bp_first_y", ry, 64);
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_d !== 1'b1 || y_d !== 8'd64 || sat_d !== 1'b0) stable = 1'b0;
      end
      check("bp_hold_stable", int'(stable), 1);
      ready_d = 1'b1;
      start_d = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("b2b_valid_fall", int'(valid_d), 0);
      check("b2b_busy_rise",  int'(busy_d),  1);
      collect(0, 1, 256, -1, ry, rsat, lat);
      $display("b2b second: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("b2b_y", ry, 255);
      check("b2b_sat", int'(rsat), 1);
      check("b2b_latency", lat, 256);
      release_result(0);

      // start pulsed mid-ACCUM is ignored
      run_meas(0, 2, 256, 100, ry, rsat, lat);
      $display("ignored start: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("ign_y", ry, 64);
      check("ign_latency", lat, 256);
      release_result(0);

      // asynchronous reset mid-ACCUM
      @(negedge clk);
      start_d = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_d = 1'b0;
      x = 1'b1;
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      $display("mid reset: busy=%0d valid=%0d y=%0d sat=%0d", busy_d, valid_d, y_d, sat_d);
      check("mrst_busy",  int'(busy_d),  0);
      check("mrst_valid", int'(valid_d), 0);
      check("mrst_y",     int'(y_d),     0);
      check("mrst_sat",   int'(sat_d),   0);
      x = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_meas(0, 3, 256, -1, ry, rsat, lat);
      $display("post reset: y=%0d sat=%0d latency=%0d", ry, rsat, lat);
      check("post_rst_y", ry, 86);
      check("post_rst_latency", lat, 256);
      release_result(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
